rv32i_lsu: RTL and testbench

RV32I_LSU -- requirements
Module: rv32i_lsu

---
 rtl/rv32i_lsu.sv | 166 ++++++++++++++++
 tb/tb_rv32i_lsu.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_lsu.sv
// rv32i_lsu: single-outstanding RV32I load/store unit driving a req/ack word bus.
// Optional RV32I_LSU_MISALIGN_TRAP_EN: misaligned H/W requests skip the bus and report misalign_o.
module rv32i_lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  input  logic        load_i,
  input  logic        store_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        misalign_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  input  logic [31:0] bus_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;
  logic [1:0]  lane_reg;
  logic [2:0]  funct3_reg;
  logic        bus_req_reg;
  logic        bus_we_reg;
  logic [31:0] bus_addr_reg;
  logic [31:0] bus_wdata_reg;
  logic [3:0]  bus_be_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;

  logic        req_valid;
  logic        is_word_in;
  logic        is_half_in;
  logic [31:0] wdata_next;
  logic [3:0]  be_next;
  logic [31:0] load_next;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // funct3[1] set means word (covers 010/011/110/111); otherwise funct3[0] picks half vs byte.
  assign req_valid  = load_i | store_i;
  assign is_word_in = funct3_i[1];
  assign is_half_in = ~funct3_i[1] & funct3_i[0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_next[8*gi +: 8] = is_word_in ? wdata_i[8*gi +: 8] :
                                     is_half_in ? wdata_i[8*(gi%2) +: 8] :
                                                  wdata_i[7:0];
      assign be_next[gi] = load_i | is_word_in |
                           (is_half_in ? (addr_i[1] == 1'(gi / 2))
                                       : (addr_i[1:0] == 2'(gi)));
    end
  endgenerate

  // Lane select and extension of the returned word, using the request latched at issue.
  always_comb begin
    byte_sel = bus_rdata_i[7:0];
    case (lane_reg)
      2'd1:    byte_sel = bus_rdata_i[15:8];
      2'd2:    byte_sel = bus_rdata_i[23:16];
      2'd3:    byte_sel = bus_rdata_i[31:24];
      default: byte_sel = bus_rdata_i[7:0];
    endcase
    half_sel  = lane_reg[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    load_next = bus_rdata_i;
    if (!funct3_reg[1]) begin
      if (funct3_reg[0])
        load_next = {{16{~funct3_reg[2] & half_sel[15]}}, half_sel};
      else
        load_next = {{24{~funct3_reg[2] & byte_sel[7]}}, byte_sel};
    end
  end

`ifdef RV32I_LSU_MISALIGN_TRAP_EN
  logic misalign_in;
  logic misalign_reg;
  assign misalign_in = is_word_in ? (addr_i[1:0] != 2'b00) : (is_half_in & addr_i[0]);
  assign misalign_o  = misalign_reg;
`else
  assign misalign_o  = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      lane_reg      <= 2'b00;
      funct3_reg    <= 3'b000;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= 32'h0;
      bus_wdata_reg <= 32'h0;
      bus_be_reg    <= 4'h0;
      rdata_reg     <= 32'h0;
      err_reg       <= 1'b0;
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
      misalign_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            lane_reg   <= addr_i[1:0];
            funct3_reg <= funct3_i;
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
            if (misalign_in) begin
              state_reg    <= DONE;
              misalign_reg <= 1'b1;
            end else
`endif
            begin
              state_reg     <= REQ;
              bus_req_reg   <= 1'b1;
              bus_we_reg    <= store_i & ~load_i;
              bus_addr_reg  <= {addr_i[31:2], 2'b00};
              bus_wdata_reg <= wdata_next;
              bus_be_reg    <= be_next;
            end
          end
        end
        REQ: begin
          if (bus_ack_i || bus_err_i) begin
            state_reg   <= DONE;
            bus_req_reg <= 1'b0;
            err_reg     <= bus_err_i;
            rdata_reg   <= (bus_err_i || bus_we_reg) ? 32'h0 : load_next;
          end
        end
        DONE: begin
          // Result fields are only meaningful for the single DONE cycle.
          state_reg <= IDLE;
          rdata_reg <= 32'h0;
          err_reg   <= 1'b0;
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
          misalign_reg <= 1'b0;
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign stall_o     = (state_reg == REQ) | ((state_reg == IDLE) & req_valid);
  assign done_o      = (state_reg == DONE);
  assign rdata_o     = rdata_reg;
  assign err_o       = err_reg;
  assign bus_req_o   = bus_req_reg;
  assign bus_we_o    = bus_we_reg;
  assign bus_addr_o  = bus_addr_reg;
  assign bus_wdata_o = bus_wdata_reg;
  assign bus_be_o    = bus_be_reg;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Testbench for rv32i_lsu: directed cases plus $urandom accesses checked against a behavioural model.
module tb_rv32i_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [2:0]  funct3_i = '0;
  logic        load_i = 1'b0;
  logic        store_i = 1'b0;
  logic        stall_o, done_o, err_o, misalign_o;
  logic [31:0] rdata_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ack_i = 1'b0;
  logic        bus_err_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;

  int total = 0;
  int bad = 0;
  int txn = 0;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic [3:0]  obs_be;
  logic        obs_err, obs_mis, obs_saw_req;
  int          obs_stall;

  rv32i_lsu dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .funct3_i(funct3_i), .load_i(load_i), .store_i(store_i),
    .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .misalign_o(misalign_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes from funct3.
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
    int sz = size_of(f3);
    return (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] d);
    int sz = size_of(f3);
    int off = (sz == 1) ? int'(a[1:0]) : (sz == 2) ? 2 * int'(a[1]) : 0;
    logic [31:0] s = d >> (8 * off);
    bit uns = (f3 == 3'b100) || (f3 == 3'b101);
    if (sz == 1) return uns ? {24'h0, s[7:0]} : 32'($signed(s[7:0]));
    if (sz == 2) return uns ? {16'h0, s[15:0]} : 32'($signed(s[15:0]));
    return d;
  endfunction

  function automatic logic [3:0] model_be(input bit is_ld, input logic [2:0] f3,
                                          input logic [31:0] a);
    int sz = size_of(f3);
    if (is_ld || sz == 4) return 4'hF;
    if (sz == 1) return 4'(4'b0001 << a[1:0]);
    return 4'(4'b0011 << (2 * int'(a[1])));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz = size_of(f3);
    if (sz == 1) return {24'h0, wd[7:0]} * 32'h01010101;
    if (sz == 2) return {16'h0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  // One complete access; wait_n extra REQ cycles before the bus responds.
  task automatic run_access(input bit ld, input bit st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input int wait_n, input bit berr);
    bit is_ld = ld;
    bit mis = model_mis(f3, a);
    logic [31:0] exp_rdata;
    exp_rdata = (mis || berr || !is_ld) ? 32'h0 : model_load(f3, a, rd);
    obs_stall = 0;
    obs_saw_req = 1'b0;
    @(negedge clk_i);
    load_i = ld; store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd;
    #1;
    chk("stall_on_request", stall_o, 1'b1);
    if (stall_o) obs_stall++;
    @(posedge clk_i); #1;
    load_i = 1'b0; store_i = 1'b0;
    addr_i = $urandom; wdata_i = $urandom; funct3_i = 3'($urandom);
    if (!mis) begin
      for (int k = 0; k <= wait_n; k++) begin
        if (k == 0) begin
          obs_addr = bus_addr_o; obs_be = bus_be_o; obs_wdata = bus_wdata_o;
          obs_saw_req = bus_req_o;
        end
        chk("req_bus_req", bus_req_o, 1'b1);
        chk("req_bus_we", bus_we_o, !is_ld);
        chk("req_bus_addr", bus_addr_o, {a[31:2], 2'b00});
        chk("req_bus_be", bus_be_o, model_be(is_ld, f3, a));
        if (!is_ld) chk("req_bus_wdata", bus_wdata_o, model_wdata(f3, wd));
        chk("req_done_low", done_o, 1'b0);
        chk("req_rdata_zero", rdata_o, 32'h0);
        if (stall_o) obs_stall++;
        if (k == wait_n) begin
          bus_ack_i = !berr; bus_err_i = berr; bus_rdata_i = rd;
        end else begin
          bus_rdata_i = $urandom;
        end
        @(posedge clk_i); #1;
        bus_ack_i = 1'b0; bus_err_i = 1'b0;
      end
    end
    obs_rdata = rdata_o; obs_err = err_o; obs_mis = misalign_o;
    chk("done_pulse", done_o, 1'b1);
    chk("done_stall_low", stall_o, 1'b0);
    chk("done_bus_req_low", bus_req_o, 1'b0);
    chk("done_rdata", rdata_o, exp_rdata);
    chk("done_err", err_o, berr && !mis);
    chk("done_misalign", misalign_o, mis);
    @(posedge clk_i); #1;
    chk("after_done_low", done_o, 1'b0);
    chk("after_rdata_zero", rdata_o, 32'h0);
    chk("after_err_zero", err_o, 1'b0);
    chk("after_mis_zero", misalign_o, 1'b0);
    $display("txn %0d ld=%0b st=%0b f3=%0d addr=%h wd=%h rd=%h wait=%0d berr=%0b -> rdata=%h err=%0b mis=%0b stall_cycles=%0d",
             txn, ld, st, f3, a, wd, rd, wait_n, berr, obs_rdata, obs_err, obs_mis, obs_stall);
    txn++;
  endtask

  initial begin
    // Reset state; stall follows load_i|store_i even while in reset.
    rst_i = 1'b1; load_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_stall_follows_load", stall_o, 1'b1);
    chk("rst_done", done_o, 1'b0);
    chk("rst_bus_req", bus_req_o, 1'b0);
    chk("rst_bus_addr", bus_addr_o, 32'h0);
    chk("rst_bus_be", bus_be_o, 4'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    load_i = 1'b0;
    #1;
    chk("rst_stall_idle", stall_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // SB to 0x1003, zero-wait ack.
    run_access(1'b0, 1'b1, 3'b000, 32'h1003, 32'h000000A5, 32'h0, 0, 1'b0);
    chk("sb_addr", obs_addr, 32'h1000);
    chk("sb_be", {28'h0, obs_be}, 32'h8);
    chk("sb_wdata", obs_wdata, 32'hA5A5A5A5);
    chk("sb_latency", obs_stall, 2);

    // Byte/half loads from a fixed bus word.
    run_access(1'b1, 1'b0, 3'b000, 32'h2001, 32'h0, 32'h1234F678, 0, 1'b0);
    chk("lb_rdata", obs_rdata, 32'hFFFFFFF6);
    run_access(1'b1, 1'b0, 3'b100, 32'h2001, 32'h0, 32'h1234F678, 0, 1'b0);
    chk("lbu_rdata", obs_rdata, 32'h000000F6);
    run_access(1'b1, 1'b0, 3'b101, 32'h2002, 32'h0, 32'h1234F678, 0, 1'b0);
    chk("lhu_rdata", obs_rdata, 32'h00001234);

    // LW with 5 wait cycles.
    run_access(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 32'hCAFEBABE, 5, 1'b0);
    chk("lw_wait_stall_cycles", obs_stall, 7);
    chk("lw_wait_rdata", obs_rdata, 32'hCAFEBABE);

    // LH from an odd address.
    run_access(1'b1, 1'b0, 3'b001, 32'h3001, 32'h0, 32'h1234F678, 0, 1'b0);
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
    chk("lh_mis_flag", obs_mis, 1'b1);
    chk("lh_mis_no_bus", obs_saw_req, 1'b0);
    chk("lh_mis_latency", obs_stall, 1);
`else
    chk("lh_odd_addr", obs_addr, 32'h3000);
    chk("lh_odd_rdata", obs_rdata, 32'hFFFFF678);
`endif

    // SW with bus error.
    run_access(1'b0, 1'b1, 3'b010, 32'h5004, 32'h11223344, 32'h0, 1, 1'b1);
    chk("sw_err", obs_err, 1'b1);

    // Load and store together behave as a load.
    run_access(1'b1, 1'b1, 3'b001, 32'h6002, 32'hFFFFFFFF, 32'h8001AAAA, 0, 1'b0);
    chk("ld_st_both_rdata", obs_rdata, 32'hFFFF8001);

    // Reset mid-transfer, followed by a late ack.
    @(negedge clk_i);
    load_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h7000;
    @(posedge clk_i); #1;
    load_i = 1'b0;
    chk("abort_in_req", bus_req_o, 1'b1);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("abort_bus_req", bus_req_o, 1'b0);
    chk("abort_done", done_o, 1'b0);
    chk("abort_stall", stall_o, 1'b0);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h12345678;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk_i); #1;
      chk("late_ack_no_done", done_o, 1'b0);
      chk("late_ack_no_req", bus_req_o, 1'b0);
      chk("late_ack_rdata", rdata_o, 32'h0);
    end
    bus_ack_i = 1'b0;

    // Randomized accesses.
    for (int i = 0; i < 60; i++) begin
      bit ld_r = 1'($urandom_range(0, 1));
      bit st_r = ld_r ? 1'($urandom_range(0, 3) == 0) : 1'b1;
      run_access(ld_r, st_r, 3'($urandom), $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
